// File: rtl/wl_afifo_rctrl_if.sv
// Read-side bus of the asynchronous FIFO: the write-pointer input, the read request,
// and everything the read controller reports back (RAM strobe, flags, gray read pointer).
interface wl_afifo_rctrl_if #(
    parameter int L = 3
);
    logic [L:0]   g_wptr;
    logic         rd_en;
    logic [L:0]   g_rptr;
    logic [L-1:0] raddr;
    logic         ram_ren;
    logic         rvalid;
    logic         rempty;
    logic         ralmost_empty;
    logic [L:0]   rcount;
    logic         rd_err;

    modport master (
        output g_wptr, rd_en,
        input  g_rptr, raddr, ram_ren, rvalid, rempty, ralmost_empty, rcount, rd_err
    );

    modport slave (
        input  g_wptr, rd_en,
        output g_rptr, raddr, ram_ren, rvalid, rempty, ralmost_empty, rcount, rd_err
    );
endinterface

// File: rtl/wl_afifo_rctrl.sv
// Read-side pointer controller of the asynchronous FIFO (rclk domain only).
// Synchronizes the gray write pointer and owns the binary/gray read pointer and read flags.
module wl_afifo_rctrl #(
    parameter int L      = 3,
    parameter int AE_LVL = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rclr,
    wl_afifo_rctrl_if.slave  bus
);
    localparam logic [L:0] AE_THR = AE_LVL[L:0];

    logic [L:0] r_gray_wptr_q, r_gray_wptr_d;
    logic [L:0] r2_gray_wptr_q, r2_gray_wptr_d;
    logic [L:0] rbin_q, rbin_d;
    logic [L:0] g_rptr_q, g_rptr_d;
    logic [L:0] rcount_q, rcount_d;
    logic       rempty_q, rempty_d;
    logic       ralmost_empty_q, ralmost_empty_d;
    logic       rvalid_q, rvalid_d;
    logic       rd_err_q, rd_err_d;

    logic       clr;
    logic       rd_fire;
    logic [L:0] rbin_next;
    logic [L:0] gray_next;
    logic [L:0] wbin_s;
    logic [L:0] fill;

    // A read is only honoured when data is present and no clear is in progress.
    always_comb begin
        clr       = rrst | rclr;
        rd_fire   = bus.rd_en & ~rempty_q & ~clr;
        rbin_next = rbin_q + {{L{1'b0}}, rd_fire};
        gray_next = rbin_next ^ (rbin_next >> 1);
        // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
        for (int i = 0; i <= L; i++) begin
            wbin_s[i] = ^(r2_gray_wptr_q >> i);
        end
        fill = wbin_s - rbin_next;
    end

    // NOTE: every *_d gets an unconditional assignment so no latch can be inferred.
    always_comb begin
        r_gray_wptr_d   = bus.g_wptr;
        r2_gray_wptr_d  = r_gray_wptr_q;
        rbin_d          = rbin_next;
        g_rptr_d        = gray_next;
        rempty_d        = (gray_next == r2_gray_wptr_q);
        rcount_d        = fill;
        ralmost_empty_d = (fill <= AE_THR);
        rvalid_d        = rd_fire;
        rd_err_d        = bus.rd_en & rempty_q & ~clr;
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge rclk) begin
        if (rrst || rclr) begin
            r_gray_wptr_q   <= '0;
            r2_gray_wptr_q  <= '0;
            rbin_q          <= '0;
            g_rptr_q        <= '0;
            rcount_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rvalid_q        <= 1'b0;
            rd_err_q        <= 1'b0;
        end else begin
            r_gray_wptr_q   <= r_gray_wptr_d;
            r2_gray_wptr_q  <= r2_gray_wptr_d;
            rbin_q          <= rbin_d;
            g_rptr_q        <= g_rptr_d;
            rcount_q        <= rcount_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rvalid_q        <= rvalid_d;
            rd_err_q        <= rd_err_d;
        end
    end

    // g_rptr crosses into wclk, so it must come straight from a flop.
    assign bus.g_rptr        = g_rptr_q;
    assign bus.raddr         = rbin_q[L-1:0];
    assign bus.ram_ren       = rd_fire;
    assign bus.rvalid        = rvalid_q;
    assign bus.rempty        = rempty_q;
    assign bus.ralmost_empty = ralmost_empty_q;
    assign bus.rcount        = rcount_q;
    assign bus.rd_err        = rd_err_q;
endmodule

// File: doc/wl_afifo_rctrl.md
Name: wl_afifo_rctrl

Overview:
- Read-side pointer controller of the asynchronous FIFO. Runs entirely in the rclk domain.
- Synchronizes the gray write pointer from the wclk domain through a two-flop stage.
- Owns the binary/gray read pointer and produces the RAM read address/enable, empty, almost-empty, fill count and underflow flags.
- Its g_rptr output is the gray read pointer that the write side synchronizes back into wclk.

Parameters:
- L, 3, address width; FIFO depth is 2^L; pointers are L+1 bits.
- AE_LVL, 1, almost-empty threshold; ralmost_empty=1 when rcount <= AE_LVL.

Ports:
- rclk  input  1  read clock; all logic on posedge.
- rrst  input  1  synchronous, active-high reset.
- rclr  input  1  synchronous clear; same effect as rrst. The write side must be cleared in the same window.
- g_wptr  input  L+1  gray write pointer, wclk domain, asynchronous to rclk.
- rd_en  input  1  read request.
- g_rptr  output  L+1  registered gray read pointer, to the write-side synchronizer.
- raddr  output  L  RAM read address, equal to rbin[L-1:0].
- ram_ren  output  1  RAM read enable (combinational, = rd_fire).
- rvalid  output  1  RAM read data valid, one cycle after ram_ren.
- rempty  output  1  registered empty flag.
- ralmost_empty  output  1  registered almost-empty flag.
- rcount  output  L+1  registered number of words available.
- rd_err  output  1  one-cycle underflow pulse.

Behaviour:
- Reset values (rrst or rclr at a posedge): pointers, synchronizer flops, g_rptr, rcount, rvalid, rd_err = 0; rempty = 1; ralmost_empty = 1.
- Priority: rrst > rclr > normal operation. rd_en is ignored in the clear cycle.
- Synchronizer: r_gray_wptr <= g_wptr, then r2_gray_wptr <= r_gray_wptr. No other logic may sample g_wptr.
- rd_fire = rd_en & ~rempty.
  - ram_ren = rd_fire.
  - raddr is taken from the current rbin.
- rbin_next = rbin + rd_fire, modulo 2^(L+1).
- gray_next = rbin_next ^ (rbin_next >> 1).
- Each cycle: rbin <= rbin_next; g_rptr <= gray_next.
- rempty <= (gray_next == r2_gray_wptr).
- Empty latency: a g_wptr change that is stable before edge 1 reaches r2_gray_wptr at edge 2. rempty deasserts at edge 3.
- Empty after last read: a read of the last word sets rempty at the same edge that advances rbin. No read-ahead beyond empty.
- Fill count:
  - wbin_s = gray-to-binary of r2_gray_wptr (prefix XOR from MSB).
  - rcount <= (wbin_s - rbin_next) mod 2^(L+1).
  - rcount is valid over the range 0..2^L.
- ralmost_empty <= ((wbin_s - rbin_next) mod 2^(L+1)) <= AE_LVL.
- rvalid <= rd_fire. Fixed one-cycle latency, matching a synchronous-read RAM.
- Underflow: rd_en while rempty=1 gives rd_err <= 1 for one cycle.
  - rbin and g_rptr are unchanged.
  - No ram_ren.
- Wrap-around:
  - raddr wraps from 2^L-1 to 0.
  - The pointer MSB toggles, and rbin wraps from 2^(L+1)-1 to 0.
  - g_rptr changes exactly one bit per increment, including across the wrap.
- Simultaneous write-pointer advance and read: both are applied in the same cycle. The rcount change is the net of the two.
- g_rptr is a flop output with no combinational path, as required for CDC.
- Full detection is outside this block (write side).

Test Plan:
- Reset: assert rrst for 2 cycles with rd_en=1 -> rempty=1, ralmost_empty=1, rcount=0, g_rptr=0, ram_ren=0, rd_err=0.
- Single write: g_wptr 0->4'b0001 -> rempty=0 at the 3rd rclk edge and rcount=1. Then pulse rd_en -> ram_ren=1 with raddr=0, rvalid=1 next cycle, rempty=1 and g_rptr=4'b0001 at the same edge.
- Full FIFO (L=3): set g_wptr=4'b1100 (binary 8) -> rcount=8, ralmost_empty=0. Hold rd_en for 8 cycles -> raddr 0..7, rcount 8 down to 0, ralmost_empty=1 once rcount<=1, rempty=1 after the 8th read.
- Underflow: with rempty=1 hold rd_en for 3 cycles -> rd_err=1 each cycle, ram_ren=0, rbin and g_rptr unchanged.
- Pointer wrap: advance through 20 writes and reads -> raddr wraps 7->0 and g_rptr visits the gray sequence 0000..1000..0000. Scoreboard checks a single bit change per increment.
- Clear mid-operation: rcount=5, assert rclr together with rd_en -> next cycle all outputs are at reset values and ram_ren=0. After g_wptr is cleared to 0, the block stays empty.
